clkdiv_multi: RTL

CLKDIV_MULTI -- requirements
Module: clkdiv_multi

---
 rtl/clkdiv_pkg.sv | 13 +
 rtl/clkdiv_chan.sv | 119 +++++++++++
 rtl/clkdiv_multi.sv | 64 ++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  // Reset-time divisor and high-time applied to every channel.
  localparam int DIV_INIT_DEF  = 50;
  localparam int HIGH_INIT_DEF = 25;

  // Width of a channel index; at least one bit even for a single channel.
  function automatic int calc_chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: active/pending configuration pair, period counter,
// registered divided clock and rising-edge tick.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIV_INIT  = DIV_INIT_DEF,
  parameter int HIGH_INIT = HIGH_INIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_div,
  input  logic [WIDTH-1:0] wr_high,
  output logic             pending,
  output logic             clkout,
  output logic             tick
);

  logic [WIDTH-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] div_a, div_next;
  logic [WIDTH-1:0] high_a, high_next;
  logic [WIDTH-1:0] pend_div, pend_div_next;
  logic [WIDTH-1:0] pend_high, pend_high_next;
  logic             pending_next;
  logic             clkout_next;
  logic             tick_next;
  // fresh: the next enabled edge starts a new period at cnt=0 (after reset,
  // or after a configuration was swapped in while the channel was disabled).
  logic             fresh, fresh_next;

  logic             stopped_old;
  logic             wrap;
  logic             apply;
  logic [WIDTH-1:0] div_use;
  logic [WIDTH-1:0] high_use;
  logic             run_use;
  logic [WIDTH-1:0] cnt_inc;

  // Next-state logic: configuration swap, counter advance and output levels.
  always_comb begin
    stopped_old = (div_a < WIDTH'(2));
    wrap        = !stopped_old && (cnt >= div_a - WIDTH'(1));
    apply       = pending && (sync || !ena || stopped_old || fresh || wrap);
    div_use     = apply ? pend_div  : div_a;
    high_use    = apply ? pend_high : high_a;
    run_use     = (div_use >= WIDTH'(2)) && (high_use != '0);
    cnt_inc     = cnt + WIDTH'(1);

    cnt_next       = cnt;
    clkout_next    = clkout;
    tick_next      = 1'b0;
    fresh_next     = fresh;
    div_next       = div_use;
    high_next      = high_use;
    pending_next   = apply ? 1'b0 : pending;
    pend_div_next  = pend_div;
    pend_high_next = pend_high;

    // A write is only accepted while nothing is pending, so it never
    // collides with the swap above and always waits for a later boundary.
    if (wr_en) begin
      pend_div_next  = wr_div;
      pend_high_next = wr_high;
      pending_next   = 1'b1;
    end

    if (sync) begin
      cnt_next    = '0;
      clkout_next = run_use;
      tick_next   = run_use;
      fresh_next  = 1'b0;
    end else if (!ena) begin
      if (apply) begin
        fresh_next = 1'b1;
      end
    end else if (div_use < WIDTH'(2)) begin
      cnt_next    = '0;
      clkout_next = 1'b0;
      fresh_next  = 1'b0;
    end else if (fresh || stopped_old || wrap) begin
      cnt_next    = '0;
      clkout_next = (high_use != '0);
      tick_next   = clkout_next && (fresh || stopped_old || apply || !clkout);
      fresh_next  = 1'b0;
    end else begin
      cnt_next    = cnt_inc;
      clkout_next = (cnt_inc < high_a);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      div_a     <= WIDTH'(DIV_INIT);
      high_a    <= WIDTH'(HIGH_INIT);
      pend_div  <= '0;
      pend_high <= '0;
      pending   <= 1'b0;
      clkout    <= 1'b0;
      tick      <= 1'b0;
      fresh     <= 1'b1;
    end else begin
      cnt       <= cnt_next;
      div_a     <= div_next;
      high_a    <= high_next;
      pend_div  <= pend_div_next;
      pend_high <= pend_high_next;
      pending   <= pending_next;
      clkout    <= clkout_next;
      tick      <= tick_next;
      fresh     <= fresh_next;
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider: write decode, ready mux and
// NCH independent divider channels.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int WIDTH     = 16,
  parameter int DIV_INIT  = DIV_INIT_DEF,
  parameter int HIGH_INIT = HIGH_INIT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            ena,
  input  logic                      sync,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [calc_chw(NCH)-1:0]  wr_ch,
  input  logic [WIDTH-1:0]          wr_div,
  input  logic [WIDTH-1:0]          wr_high,
  output logic [NCH-1:0]            clkout,
  output logic [NCH-1:0]            tick
);

  localparam int CHW = calc_chw(NCH);

  logic [NCH-1:0] pending;
  logic [NCH-1:0] wr_en;

  // Ready mux: an out-of-range channel matches nothing, so it reads ready
  // and the write is silently dropped.
  always_comb begin
    wr_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (wr_ch == CHW'(i)) begin
        wr_ready = !pending[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign wr_en[gi] = wr_valid && wr_ready && (wr_ch == CHW'(gi));

      clkdiv_chan #(
        .WIDTH     (WIDTH),
        .DIV_INIT  (DIV_INIT),
        .HIGH_INIT (HIGH_INIT)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena[gi]),
        .sync    (sync),
        .wr_en   (wr_en[gi]),
        .wr_div  (wr_div),
        .wr_high (wr_high),
        .pending (pending[gi]),
        .clkout  (clkout[gi]),
        .tick    (tick[gi])
      );
    end
  endgenerate

endmodule
